huff_pair_unpacker: RTL and testbench
=====================================

Name: huff_pair_unpacker

Overview:
- Sits between the serial bitstream source and one Huffman table decoder (ht_*) in the big_values region of a granule.
- Routes codeword bits to the table decoder and latches the decoded (x,y) magnitude pair.
- Consumes the linbits and sign bits that follow the codeword from the same stream.
- Emits signed x/y sample values, one pair per pulse, until big_values pairs are done.

Parameters:
- LINBITS, 0: linbits for the selected table, range 0..13; 0 means no escape bits.
- OUT_W, 16: width of the signed output samples.
- CNT_W, 9: width of the pair count (big_values max 288).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse to begin a region; samples big_values
- big_values  in  CNT_W  number of pairs to decode
- bit_valid  in  1  serial stream bit present
- bit_data  in  1  serial stream bit
- bit_ready  out  1  block consumes bit_data this cycle when bit_valid is high
- ht_valid  out  1  bit forwarded to the table decoder (its axiiv)
- ht_data  out  1  forwarded bit (its axiid)
- ht_axiov  in  1  table decoder codeword-complete flag
- ht_err  in  1  table decoder no-match flag
- ht_x  in  4  decoded x magnitude
- ht_y  in  4  decoded y magnitude
- pair_valid  out  1  one-cycle pulse, x_out/y_out valid
- x_out  out  OUT_W  signed x sample
- y_out  out  OUT_W  signed y sample
- done  out  1  one-cycle pulse after the last pair
- err  out  1  sticky decode error

Behaviour:
- Reset (async): state IDLE, pair counter 0, x_out/y_out 0. All of pair_valid, done, err, bit_ready and ht_valid are 0.
- States: IDLE, CODE, LINX, SIGNX, LINY, SIGNY, EMIT, DONE, ERR.
- IDLE:
  - start with big_values==0 -> DONE.
  - start with big_values!=0 -> CODE, counter cleared.
  - start is ignored in every other state except ERR.
- CODE:
  - bit_ready = !ht_axiov && !ht_err.
  - ht_valid = bit_valid && bit_ready; ht_data = bit_data.
  - No bit is forwarded in the cycle ht_axiov or ht_err is high, so the decoder re-arms with zero bits.
  - On ht_axiov: latch xm=ht_x, ym=ht_y.
  - ht_err takes priority over ht_axiov -> ERR.
- Next-state selection after CODE and after each later state, in this order, skipping any that do not apply:
  - LINX if LINBITS>0 && xm==15.
  - SIGNX if xm!=0.
  - LINY if LINBITS>0 && ym==15.
  - SIGNY if ym!=0.
  - EMIT otherwise.
- LINX / LINY:
  - bit_ready=1; consume exactly LINBITS bits, MSB first, via an internal bit counter.
  - Magnitude becomes 15 + linbits value.
  - Stalls, with no count advance, while bit_valid=0.
- SIGNX / SIGNY:
  - bit_ready=1; consume one bit; 1 = negative.
  - The value is stored as its two's-complement negation at OUT_W.
- EMIT:
  - One cycle; pair_valid=1 with x_out/y_out; bit_ready=0; counter++.
  - Counter equal to big_values -> DONE, else CODE.
  - x_out/y_out hold their value until the next EMIT.
- DONE: done=1 for one cycle -> IDLE.
- ERR:
  - err=1 (sticky); bit_ready=0; no pair_valid.
  - start clears err and restarts as from IDLE.
- Width: magnitude ≤ 15+8191 = 8206; OUT_W must be ≥15. The sign-extend/negate is exact at OUT_W.
- Stream latency: one bit per cycle max. After the last bit of a pair, pair_valid appears on the next cycle.
- Reset mid-operation: immediate return to IDLE. The decoder shares rst and is cleared at the same time.

Test Plan:
- LINBITS=0 with HT_5, start big_values=1, stream "1":
  - Required: pair_valid with x=0, y=0; no sign bits consumed; done 1 cycle later.
- big_values=3, stream "011 0", "010 1", "001 1 0":
  - Required: pairs (+1,0), (0,-1), (-1,+1); done after the third pair_valid.
  - Required: bit_ready is low in each EMIT cycle.
- LINBITS=4 with a stub decoder returning x=15, y=0, stream after the codeword "0101 1":
  - Required: x_out = -20, y_out = 0.
- LINBITS=4, x=15 with linbits "1111", sign 0:
  - Required: x_out = +30.
- Stub asserts ht_err mid-codeword:
  - Required: err high, no pair_valid, bit_ready 0.
  - A new start clears err and the next pair decodes correctly.
- Exercise start with big_values=0, bit_valid gaps inside LINX, and rst asserted during SIGNY:
  - Required: done next cycle for big_values=0.
  - Required: gaps cause a stall with no lost bits.
  - Required: reset gives all outputs 0 and state IDLE asynchronously.

Source files
------------

// File: rtl/huff_pair_unpacker.sv
// Big_values pair unpacker: steers codeword bits to a Huffman table decoder, then
// pulls linbits/sign bits from the same serial stream and emits signed (x,y) pairs.
module huff_pair_unpacker #(
  parameter int LINBITS = 0,
  parameter int OUT_W   = 16,
  parameter int CNT_W   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        big_values,
  input  logic                    bit_valid,
  input  logic                    bit_data,
  output logic                    bit_ready,
  output logic                    ht_valid,
  output logic                    ht_data,
  input  logic                    ht_axiov,
  input  logic                    ht_err,
  input  logic [3:0]              ht_x,
  input  logic [3:0]              ht_y,
  output logic                    pair_valid,
  output logic signed [OUT_W-1:0] x_out,
  output logic signed [OUT_W-1:0] y_out,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [3:0] {
    IDLE, CODE, LINX, SIGNX, LINY, SIGNY, EMIT, DONE, ERR
  } state_t;

  localparam int         LIN_W    = (LINBITS > 0) ? LINBITS : 1;
  localparam logic [3:0] LIN_LAST = 4'(LIN_W - 1);

  state_t             state, state_next;
  logic [3:0]         xm, xm_next, ym, ym_next;
  logic [OUT_W-1:0]   xv, xv_next, yv, yv_next;
  logic [LIN_W-1:0]   lin_acc, lin_acc_next, lin_sh;
  logic [3:0]         lin_cnt, lin_cnt_next;
  logic               lin_last;
  logic [OUT_W-1:0]   lin_mag;
  logic [CNT_W-1:0]   cnt, cnt_next, bv_reg, bv_next;

  // Next stage of a pair after finishing stage 'from'; later stages never revisit earlier ones.
  function automatic state_t route(input state_t from, input logic [3:0] mx, input logic [3:0] my);
    if (from == CODE && LINBITS > 0 && mx == 4'd15)
      route = LINX;
    else if ((from == CODE || from == LINX) && mx != 4'd0)
      route = SIGNX;
    else if ((from == CODE || from == LINX || from == SIGNX) && LINBITS > 0 && my == 4'd15)
      route = LINY;
    else if (from != SIGNY && my != 4'd0)
      route = SIGNY;
    else
      route = EMIT;
  endfunction

  assign ht_data = bit_data;

  always_comb begin
    state_next   = state;
    xm_next      = xm;
    ym_next      = ym;
    xv_next      = xv;
    yv_next      = yv;
    lin_acc_next = lin_acc;
    lin_cnt_next = lin_cnt;
    cnt_next     = cnt;
    bv_next      = bv_reg;
    bit_ready    = 1'b0;
    ht_valid     = 1'b0;
    lin_sh       = LIN_W'({lin_acc, bit_data});
    lin_mag      = OUT_W'(4'd15) + OUT_W'(lin_sh);
    lin_last     = (lin_cnt == LIN_LAST);

    case (state)
      IDLE, ERR: begin
        if (start) begin
          bv_next    = big_values;
          cnt_next   = '0;
          state_next = (big_values == '0) ? DONE : CODE;
        end
      end
      CODE: begin
        // Hold the stream while the decoder reports, so it re-arms with no bits taken.
        bit_ready = !ht_axiov && !ht_err;
        ht_valid  = bit_valid && bit_ready;
        if (ht_err) begin
          state_next = ERR;
        end else if (ht_axiov) begin
          xm_next    = ht_x;
          ym_next    = ht_y;
          xv_next    = OUT_W'(ht_x);
          yv_next    = OUT_W'(ht_y);
          state_next = route(CODE, ht_x, ht_y);
        end
      end
      LINX: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          if (lin_last) begin
            xv_next      = lin_mag;
            lin_acc_next = '0;
            lin_cnt_next = '0;
            state_next   = route(LINX, xm, ym);
          end else begin
            lin_acc_next = lin_sh;
            lin_cnt_next = lin_cnt + 4'd1;
          end
        end
      end
      SIGNX: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          if (bit_data) xv_next = -xv;
          state_next = route(SIGNX, xm, ym);
        end
      end
      LINY: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          if (lin_last) begin
            yv_next      = lin_mag;
            lin_acc_next = '0;
            lin_cnt_next = '0;
            state_next   = route(LINY, xm, ym);
          end else begin
            lin_acc_next = lin_sh;
            lin_cnt_next = lin_cnt + 4'd1;
          end
        end
      end
      SIGNY: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          if (bit_data) yv_next = -yv;
          state_next = route(SIGNY, xm, ym);
        end
      end
      EMIT: begin
        cnt_next   = cnt + CNT_W'(1);
        state_next = (cnt_next == bv_reg) ? DONE : CODE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      xm         <= '0;
      ym         <= '0;
      xv         <= '0;
      yv         <= '0;
      lin_acc    <= '0;
      lin_cnt    <= '0;
      cnt        <= '0;
      bv_reg     <= '0;
      pair_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
    end else begin
      state      <= state_next;
      xm         <= xm_next;
      ym         <= ym_next;
      xv         <= xv_next;
      yv         <= yv_next;
      lin_acc    <= lin_acc_next;
      lin_cnt    <= lin_cnt_next;
      cnt        <= cnt_next;
      bv_reg     <= bv_next;
      pair_valid <= (state_next == EMIT);
      done       <= (state_next == DONE);
      err        <= (state_next == ERR);
      if (state_next == EMIT) begin
        x_out <= xv_next;
        y_out <= yv_next;
      end
    end
  end

endmodule

// File: tb/tb_huff_pair_unpacker.sv
// Directed bench for huff_pair_unpacker: two instances (LINBITS 0 and 4), each fed by
// a tiny prefix-code stub decoder: 1->(0,0) 011->(1,0) 010->(0,1) 001->(1,1) 0001->(15,0) 0000->err.
module tb_huff_pair_unpacker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_s = 2'b00;
  logic [1:0] bvalid_s = 2'b00;
  logic       bit_data = 1'b0;
  logic [8:0] big_values = '0;

  logic [1:0]         bit_ready_w, ht_valid_w, ht_data_w, pair_valid_w, done_w, err_w;
  logic signed [15:0] x_w [2];
  logic signed [15:0] y_w [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int pv_cnt [2]   = '{0, 0};
  int pv_cyc [2]   = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int viol [2]     = '{0, 0};
  logic signed [15:0] hist_x [2][16];
  logic signed [15:0] hist_y [2][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] lookup(input logic [4:0] code, input logic [2:0] n);
    lookup = '0;
    case (n)
      3'd1: if (code[0]) lookup = {2'b10, 4'd0, 4'd0};
      3'd3: begin
        case (code[2:0])
          3'b011:  lookup = {2'b10, 4'd1, 4'd0};
          3'b010:  lookup = {2'b10, 4'd0, 4'd1};
          3'b001:  lookup = {2'b10, 4'd1, 4'd1};
          default: lookup = '0;
        endcase
      end
      3'd4: begin
        if (code[3:0] == 4'b0001)      lookup = {2'b10, 4'd15, 4'd0};
        else if (code[3:0] == 4'b0000) lookup = {2'b01, 8'd0};
      end
      default: lookup = '0;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic               br, hv, hd, pv, dn, er;
    logic signed [15:0] xo, yo;
    logic               axiov, herr;
    logic [3:0]         hx, hy, sr;
    logic [2:0]         len;
    logic [9:0]         look;

    huff_pair_unpacker #(.LINBITS(gi * 4), .OUT_W(16), .CNT_W(9)) u_dut (
      .clk(clk), .rst(rst), .start(start_s[gi]), .big_values(big_values),
      .bit_valid(bvalid_s[gi]), .bit_data(bit_data), .bit_ready(br),
      .ht_valid(hv), .ht_data(hd), .ht_axiov(axiov), .ht_err(herr),
      .ht_x(hx), .ht_y(hy), .pair_valid(pv), .x_out(xo), .y_out(yo),
      .done(dn), .err(er)
    );

    assign look = lookup({sr, hd}, len + 3'd1);

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        axiov <= 1'b0; herr <= 1'b0; hx <= '0; hy <= '0; sr <= '0; len <= '0;
      end else begin
        axiov <= 1'b0;
        herr  <= 1'b0;
        if (hv) begin
          if (look[9]) begin
            axiov <= 1'b1; hx <= look[7:4]; hy <= look[3:0]; sr <= '0; len <= '0;
          end else if (look[8]) begin
            herr <= 1'b1; sr <= '0; len <= '0;
          end else begin
            sr <= {sr[2:0], hd}; len <= len + 3'd1;
          end
        end
      end
    end

    assign bit_ready_w[gi]  = br;
    assign ht_valid_w[gi]   = hv;
    assign ht_data_w[gi]    = hd;
    assign pair_valid_w[gi] = pv;
    assign done_w[gi]       = dn;
    assign err_w[gi]        = er;
    assign x_w[gi]          = xo;
    assign y_w[gi]          = yo;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pair_valid_w[d]) begin
        hist_x[d][pv_cnt[d] % 16] <= x_w[d];
        hist_y[d][pv_cnt[d] % 16] <= y_w[d];
        pv_cyc[d] <= cyc;
        pv_cnt[d] <= pv_cnt[d] + 1;
        if (bit_ready_w[d]) viol[d] <= viol[d] + 1;
      end
      if (done_w[d]) begin
        done_cnt[d] <= done_cnt[d] + 1;
        done_cyc[d] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic do_start(input int d, input logic [8:0] bv);
    big_values = bv;
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  task automatic send_bit(input int d, input logic b);
    int k = 0;
    logic taken = 1'b0;
    bvalid_s[d] = 1'b1;
    bit_data = b;
    while (!taken && k < 40) begin
      @(negedge clk);
      if (bit_ready_w[d]) begin
        @(posedge clk); #1;
        taken = 1'b1;
      end
      k++;
    end
    bvalid_s[d] = 1'b0;
    if (!taken) chk("bit_accept", 32'(taken), 32'd1);
  endtask

  task automatic send_bits(input int d, input string s);
    for (int i = 0; i < s.len(); i++)
      if (s[i] == "0" || s[i] == "1") send_bit(d, s[i] == "1");
  endtask

  task automatic gap(input int d, input int n);
    bvalid_s[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int n0, input string tag);
    int k = 0;
    while (done_cnt[d] == n0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk(tag, 32'(done_cnt[d] - n0), 32'd1);
  endtask

  task automatic chk_cleared(input int d, input string tag);
    chk({tag, "_pv"}, 32'(pair_valid_w[d]), 32'd0);
    chk({tag, "_done"}, 32'(done_w[d]), 32'd0);
    chk({tag, "_err"}, 32'(err_w[d]), 32'd0);
    chk({tag, "_rdy"}, 32'(bit_ready_w[d]), 32'd0);
    chk({tag, "_htv"}, 32'(ht_valid_w[d]), 32'd0);
    chk({tag, "_x"}, 32'(x_w[d]), 32'd0);
    chk({tag, "_y"}, 32'(y_w[d]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0;
    repeat (3) @(posedge clk);
    #2;
    chk_cleared(0, "reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // LINBITS=0, single (0,0) pair from codeword "1"
    p0 = pv_cnt[0]; d0 = done_cnt[0];
    do_start(0, 9'd1);
    send_bits(0, "1");
    wait_done(0, d0, "a_done");
    chk("a_npairs", 32'(pv_cnt[0] - p0), 32'd1);
    chk("a_x", 32'(hist_x[0][p0 % 16]), 32'd0);
    chk("a_y", 32'(hist_y[0][p0 % 16]), 32'd0);
    chk("a_done_lat", 32'(done_cyc[0] - pv_cyc[0]), 32'd1);

    // three pairs with sign bits
    p0 = pv_cnt[1]; d0 = done_cnt[1];
    do_start(1, 9'd3);
    send_bits(1, "011 0 010 1 001 1 0");
    wait_done(1, d0, "b_done");
    chk("b_npairs", 32'(pv_cnt[1] - p0), 32'd3);
    chk("b_x0", 32'(hist_x[1][(p0 + 0) % 16]), 32'(1));
    chk("b_y0", 32'(hist_y[1][(p0 + 0) % 16]), 32'(0));
    chk("b_x1", 32'(hist_x[1][(p0 + 1) % 16]), 32'(0));
    chk("b_y1", 32'(hist_y[1][(p0 + 1) % 16]), 32'(-1));
    chk("b_x2", 32'(hist_x[1][(p0 + 2) % 16]), 32'(-1));
    chk("b_y2", 32'(hist_y[1][(p0 + 2) % 16]), 32'(1));
    chk("b_emit_rdy", 32'(viol[1]), 32'd0);
    chk("b_done_lat", 32'(done_cyc[1] - pv_cyc[1]), 32'd1);

    // escape: x=15, linbits 0101, sign 1 -> -20
    p0 = pv_cnt[1]; d0 = done_cnt[1];
    do_start(1, 9'd1);
    send_bits(1, "0001 0101 1");
    wait_done(1, d0, "c_done");
    chk("c_x", 32'(hist_x[1][p0 % 16]), 32'(-20));
    chk("c_y", 32'(hist_y[1][p0 % 16]), 32'(0));
    repeat (3) @(negedge clk);
    chk("c_x_hold", 32'(x_w[1]), 32'(-20));

    // escape with bit_valid gaps inside linbits: 1111, sign 0 -> +30
    p0 = pv_cnt[1]; d0 = done_cnt[1];
    do_start(1, 9'd1);
    send_bits(1, "0001");
    send_bit(1, 1'b1); gap(1, 3);
    send_bit(1, 1'b1); gap(1, 2);
    send_bits(1, "11");
    gap(1, 2);
    send_bit(1, 1'b0);
    wait_done(1, d0, "d_done");
    chk("d_x", 32'(hist_x[1][p0 % 16]), 32'(30));
    chk("d_y", 32'(hist_y[1][p0 % 16]), 32'(0));

    // decoder error mid-region, then recovery by start
    p0 = pv_cnt[1];
    do_start(1, 9'd2);
    send_bits(1, "0000");
    repeat (3) @(negedge clk);
    chk("e_err", 32'(err_w[1]), 32'd1);
    bvalid_s[1] = 1'b1;
    @(negedge clk);
    chk("e_rdy", 32'(bit_ready_w[1]), 32'd0);
    bvalid_s[1] = 1'b0;
    chk("e_no_pv", 32'(pv_cnt[1] - p0), 32'd0);
    d0 = done_cnt[1];
    do_start(1, 9'd1);
    chk("e_err_clr", 32'(err_w[1]), 32'd0);
    send_bits(1, "011 1");
    wait_done(1, d0, "e_done");
    chk("e_x", 32'(hist_x[1][p0 % 16]), 32'(-1));
    chk("e_y", 32'(hist_y[1][p0 % 16]), 32'(0));

    // big_values==0 finishes straight away
    do_start(1, 9'd0);
    @(negedge clk);
    chk("f_done", 32'(done_w[1]), 32'd1);
    @(negedge clk);
    chk("f_done_pulse", 32'(done_w[1]), 32'd0);

    // async reset while waiting for the y sign bit
    do_start(1, 9'd1);
    send_bits(1, "001 1");
    @(negedge clk);
    chk("g_in_sign", 32'(bit_ready_w[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk_cleared(1, "g_rst");
    @(negedge clk);
    rst = 1'b0;
    p0 = pv_cnt[1]; d0 = done_cnt[1];
    @(posedge clk); #1;
    do_start(1, 9'd1);
    send_bits(1, "1");
    wait_done(1, d0, "g_done");
    chk("g_x", 32'(hist_x[1][p0 % 16]), 32'(0));
    chk("g_npairs", 32'(pv_cnt[1] - p0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
